// File: rtl/enc_hv_collect.sv
// enc_hv_collect: reassembles a hypervector from DIMS_PER_CC-bit slices that arrive one per cycle
// from the encoder datapath, then offers it downstream over a valid/ready handshake.
// chunk_ctr doubles as the slice-select of the upstream encoder mux.
// Optional feature macro: ENC_HV_POPCOUNT_EN adds the hv_ones popcount output.
module enc_hv_collect #(
  parameter int unsigned HV_DIM      = 5000,
  parameter int unsigned DIMS_PER_CC = 500,
  parameter int unsigned NUM_CHUNKS  = 10,
  parameter int unsigned CTR_W       = 4,
  localparam int unsigned ONES_W     = $clog2(HV_DIM + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   chunk_valid,
  output logic                   chunk_ready,
  input  logic [DIMS_PER_CC-1:0] chunk_data,
  output logic [CTR_W-1:0]       chunk_ctr,
  output logic                   hv_valid,
  input  logic                   hv_ready,
`ifdef ENC_HV_POPCOUNT_EN
  output logic [ONES_W-1:0]      hv_ones,
`endif
  output logic [HV_DIM-1:0]      hv_out
);

  // Parameter consistency: slices must tile the hypervector exactly and the counter must reach them all.
  if (HV_DIM != NUM_CHUNKS * DIMS_PER_CC) begin : g_chk_tiling
    $error("enc_hv_collect: HV_DIM must equal NUM_CHUNKS*DIMS_PER_CC");
  end
  if ((64'd1 << CTR_W) < 64'(NUM_CHUNKS)) begin : g_chk_ctr_w
    $error("enc_hv_collect: CTR_W too narrow for NUM_CHUNKS");
  end

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CTR_W-1:0]   ctr_d;
  logic               accept;
  logic               last_slice;

  // A slice is taken only while collecting; a simultaneous flush discards it.
  assign accept     = chunk_valid & chunk_ready & ~flush;
  assign last_slice = (chunk_ctr == CTR_W'(NUM_CHUNKS - 1));

  // Next-state and slice-counter logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    ctr_d   = chunk_ctr;
    if (flush) begin
      state_d = S_COLLECT;
      ctr_d   = '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (accept) begin
            if (last_slice) begin
              ctr_d   = '0;
              state_d = S_HOLD;
            end else begin
              ctr_d = chunk_ctr + CTR_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (hv_ready) begin
            state_d = S_COLLECT;
          end
        end
        default: state_d = S_COLLECT;
      endcase
    end
  end

  // State, counter and handshake flags; flags are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_COLLECT;
      chunk_ctr   <= '0;
      chunk_ready <= 1'b1;
      hv_valid    <= 1'b0;
    end else begin
      state_q     <= state_d;
      chunk_ctr   <= ctr_d;
      chunk_ready <= (state_d == S_COLLECT);
      hv_valid    <= (state_d == S_HOLD);
    end
  end

  // Each accepted slice overwrites only its own field; chunk_data is never sampled otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_out <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CHUNKS; k++) begin
        if (accept && (chunk_ctr == CTR_W'(k))) begin
          hv_out[k*DIMS_PER_CC +: DIMS_PER_CC] <= chunk_data;
        end
      end
    end
  end

`ifdef ENC_HV_POPCOUNT_EN
  logic [ONES_W-1:0] slice_ones;

  assign slice_ones = ONES_W'($countones(chunk_data));

  // Running popcount; slice 0 of a new hypervector restarts the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_ones <= '0;
    end else if (flush) begin
      hv_ones <= '0;
    end else if (accept) begin
      if (chunk_ctr == '0) begin
        hv_ones <= slice_ones;
      end else begin
        hv_ones <= hv_ones + slice_ones;
      end
    end
  end
`endif

endmodule

// File: tb/tb_enc_hv_collect.sv
// Self-checking bench for enc_hv_collect: slice-list reference model compared every cycle,
// plus directed literal checks for reset, ordering, hold, flush, async reset and back-to-back HVs.
module tb_enc_hv_collect;

  localparam int unsigned HV_DIM = 5000;
  localparam int unsigned DPC    = 500;
  localparam int unsigned NCH    = 10;
  localparam int unsigned CTR_W  = 4;
  localparam int unsigned ONES_W = 13;

  logic              clk         = 1'b0;
  logic              rst_n       = 1'b0;
  logic              flush       = 1'b0;
  logic              chunk_valid = 1'b0;
  logic              hv_ready    = 1'b0;
  logic [DPC-1:0]    chunk_data  = '0;
  logic              chunk_ready;
  logic              hv_valid;
  logic [CTR_W-1:0]  chunk_ctr;
  logic [HV_DIM-1:0] hv_out;
`ifdef ENC_HV_POPCOUNT_EN
  logic [ONES_W-1:0] hv_ones;
`endif

  enc_hv_collect #(
    .HV_DIM(HV_DIM), .DIMS_PER_CC(DPC), .NUM_CHUNKS(NCH), .CTR_W(CTR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .chunk_valid(chunk_valid), .chunk_ready(chunk_ready), .chunk_data(chunk_data),
    .chunk_ctr(chunk_ctr), .hv_valid(hv_valid), .hv_ready(hv_ready),
`ifdef ENC_HV_POPCOUNT_EN
    .hv_ones(hv_ones),
`endif
    .hv_out(hv_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input bit ok, input string detail);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Reference model: the list of slices of the current hypervector and whether it is complete.
  logic [DPC-1:0] m_slice [NCH];
  int             m_count;
  bit             m_full;
  bit             m_known;
  int             m_ones;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) m_slice[k] = '0;
      m_count = 0;
      m_full  = 1'b0;
      m_known = 1'b1;
      m_ones  = 0;
    end else if (flush) begin
      m_count = 0;
      m_full  = 1'b0;
      m_known = 1'b0;
      m_ones  = 0;
    end else if (m_full) begin
      if (hv_ready) m_full = 1'b0;
    end else if (chunk_valid) begin
      if (m_count == 0) m_ones = 0;
      m_slice[m_count] = chunk_data;
      m_ones  += $countones(chunk_data);
      m_count++;
      if (m_count == NCH) begin
        m_count = 0;
        m_full  = 1'b1;
        m_known = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, plus hv_valid pulse bookkeeping.
  bit chk_en = 1'b0;
  int cyc    = 0;
  bit prev_v = 1'b0;
  int vhigh  = 0;
  int rise_q[$];
  int ones_q[$];

  always @(negedge clk) begin
    logic [HV_DIM-1:0] exp_hv;
    logic [HV_DIM-1:0] diff;
    cyc++;
    if (chk_en) begin
      for (int k = 0; k < NCH; k++) exp_hv[k*DPC +: DPC] = m_slice[k];
      check("cyc_chunk_ready", chunk_ready == !m_full,
            $sformatf("cycle %0d got %0b want %0b", cyc, chunk_ready, !m_full));
      check("cyc_hv_valid", hv_valid == m_full,
            $sformatf("cycle %0d got %0b want %0b", cyc, hv_valid, m_full));
      check("cyc_chunk_ctr", chunk_ctr == CTR_W'(m_count),
            $sformatf("cycle %0d got %0d want %0d", cyc, chunk_ctr, m_count));
      if (m_known) begin
        diff = hv_out ^ exp_hv;
        check("cyc_hv_out", diff == '0,
              $sformatf("cycle %0d: %0d bits differ from model", cyc, $countones(diff)));
      end
`ifdef ENC_HV_POPCOUNT_EN
      check("cyc_hv_ones", hv_ones == ONES_W'(m_ones),
            $sformatf("cycle %0d got %0d want %0d", cyc, hv_ones, m_ones));
      if (hv_valid && !prev_v) ones_q.push_back(int'(hv_ones));
`endif
      if (hv_valid && !prev_v) rise_q.push_back(cyc);
      if (hv_valid) vhigh++;
      prev_v = hv_valid;
    end
  end

  function automatic logic [DPC-1:0] rand_slice();
    logic [511:0] t;
    for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
    return t[DPC-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one slice and hold it until an edge where the block was ready for it.
  task automatic send(input logic [DPC-1:0] d);
    bit acc;
    int budget;
    acc    = 1'b0;
    budget = 50;
    chunk_valid = 1'b1;
    chunk_data  = d;
    while (!acc && budget > 0) begin
      acc = chunk_ready;
      tick();
      budget--;
    end
    check("send_accept", acc, $sformatf("slice not accepted within 50 cycles, ctr=%0d", chunk_ctr));
  endtask

  task automatic idle();
    chunk_valid = 1'b0;
    chunk_data  = rand_slice();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, ctr=%0d", chunk_ctr);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DPC-1:0]    d;
    logic [HV_DIM-1:0] snap;
    int                accepted;
    int                budget;

    // Reset values while rst_n is held low
    repeat (2) @(posedge clk);
    #2;
    check("rst_chunk_ctr", chunk_ctr == '0, $sformatf("got %0d want 0", chunk_ctr));
    check("rst_hv_valid", hv_valid == 1'b0, $sformatf("got %0b want 0", hv_valid));
    check("rst_chunk_ready", chunk_ready == 1'b1, $sformatf("got %0b want 1", chunk_ready));
    check("rst_hv_out", hv_out == '0, $sformatf("%0d bits set, want 0", $countones(hv_out)));
`ifdef ENC_HV_POPCOUNT_EN
    check("rst_hv_ones", hv_ones == '0, $sformatf("got %0d want 0", hv_ones));
`endif
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // T1: back-to-back slices, slice k all bits = k[0]
    hv_ready = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      check("t1_ctr", chunk_ctr == CTR_W'(k), $sformatf("got %0d want %0d", chunk_ctr, k));
      check("t1_not_valid", hv_valid == 1'b0, $sformatf("before slice %0d got %0b want 0", k, hv_valid));
      d = (k % 2 == 1) ? '1 : '0;
      send(d);
    end
    idle();
    check("t1_valid", hv_valid == 1'b1, $sformatf("got %0b want 1", hv_valid));
    check("t1_ctr_wrap", chunk_ctr == '0, $sformatf("got %0d want 0", chunk_ctr));
    for (int k = 0; k < NCH; k++) begin
      d = (k % 2 == 1) ? '1 : '0;
      check("t1_field", hv_out[k*DPC +: DPC] == d,
            $sformatf("field %0d has %0d ones, want %0d", k, $countones(hv_out[k*DPC +: DPC]), (k % 2) * DPC));
    end
`ifdef ENC_HV_POPCOUNT_EN
    check("t1_hv_ones", hv_ones == ONES_W'(2500), $sformatf("got %0d want 2500", hv_ones));
`endif
    hv_ready = 1'b1;
    tick();
    hv_ready = 1'b0;
    check("t1_release", hv_valid == 1'b0 && chunk_ready == 1'b1,
          $sformatf("hv_valid=%0b chunk_ready=%0b want 0/1", hv_valid, chunk_ready));

    // T2: random gaps and data
    accepted = 0;
    budget   = 300;
    while (accepted < NCH && budget > 0) begin
      if ($urandom_range(0, 1) == 1) begin
        chunk_valid = 1'b1;
        chunk_data  = rand_slice();
        if (chunk_ready) accepted++;
      end else begin
        idle();
      end
      tick();
      budget--;
    end
    idle();
    check("t2_complete", accepted == NCH && hv_valid == 1'b1,
          $sformatf("accepted %0d hv_valid=%0b want %0d/1", accepted, hv_valid, NCH));

    // T3: downstream stalls for 20 cycles while extra slices are offered
    snap = hv_out;
    repeat (20) begin
      chunk_valid = 1'b1;
      chunk_data  = rand_slice();
      tick();
    end
    check("t3_stable", hv_out == snap, $sformatf("%0d bits changed during hold", $countones(hv_out ^ snap)));
    check("t3_hold", hv_valid == 1'b1 && chunk_ready == 1'b0 && chunk_ctr == '0,
          $sformatf("hv_valid=%0b chunk_ready=%0b ctr=%0d want 1/0/0", hv_valid, chunk_ready, chunk_ctr));
    idle();
    hv_ready = 1'b1;
    tick();
    hv_ready = 1'b0;
    check("t3_release", hv_valid == 1'b0 && chunk_ready == 1'b1,
          $sformatf("hv_valid=%0b chunk_ready=%0b want 0/1", hv_valid, chunk_ready));

    // T4: flush together with slice 6
    for (int k = 0; k < 6; k++) send(rand_slice());
    check("t4_ctr6", chunk_ctr == CTR_W'(6), $sformatf("got %0d want 6", chunk_ctr));
    flush       = 1'b1;
    chunk_valid = 1'b1;
    chunk_data  = rand_slice();
    tick();
    flush = 1'b0;
    idle();
    check("t4_flush", chunk_ctr == '0 && hv_valid == 1'b0 && chunk_ready == 1'b1,
          $sformatf("ctr=%0d hv_valid=%0b chunk_ready=%0b want 0/0/1", chunk_ctr, hv_valid, chunk_ready));
`ifdef ENC_HV_POPCOUNT_EN
    check("t4_flush_ones", hv_ones == '0, $sformatf("got %0d want 0", hv_ones));
`endif
    for (int k = 0; k < NCH; k++) send(DPC'(k + 1));
    idle();
    check("t4_valid", hv_valid == 1'b1, $sformatf("got %0b want 1", hv_valid));
    check("t4_field6", hv_out[6*DPC +: DPC] == DPC'(7), $sformatf("low word %0d want 7", hv_out[6*DPC +: 32]));
`ifdef ENC_HV_POPCOUNT_EN
    check("t4_hv_ones", hv_ones == ONES_W'(17), $sformatf("got %0d want 17", hv_ones));
`endif
    hv_ready = 1'b1;
    tick();
    hv_ready = 1'b0;

    // T5: async reset mid-hypervector, then mid-hold
    for (int k = 0; k < 4; k++) send(rand_slice());
    idle();
    check("t5_ctr4", chunk_ctr == CTR_W'(4), $sformatf("got %0d want 4", chunk_ctr));
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_ctr", chunk_ctr == '0 && hv_valid == 1'b0 && chunk_ready == 1'b1,
          $sformatf("ctr=%0d hv_valid=%0b chunk_ready=%0b want 0/0/1", chunk_ctr, hv_valid, chunk_ready));
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < NCH; k++) send(rand_slice());
    idle();
    check("t5_valid", hv_valid == 1'b1, $sformatf("got %0b want 1", hv_valid));
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_hold", hv_valid == 1'b0 && chunk_ready == 1'b1 && hv_out == '0,
          $sformatf("hv_valid=%0b chunk_ready=%0b ones_in_hv=%0d want 0/1/0", hv_valid, chunk_ready, $countones(hv_out)));
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < NCH; k++) send(rand_slice());
    idle();
    check("t5_recover", hv_valid == 1'b1, $sformatf("got %0b want 1", hv_valid));
    hv_ready = 1'b1;
    tick();

    // T6: two hypervectors back-to-back, hv_ready tied high
    rise_q.delete();
    ones_q.delete();
    vhigh = 0;
    for (int h = 0; h < 2; h++) begin
      for (int k = 0; k < NCH; k++) begin
        if (h == 0) d = '1;
        else d = (k == 0) ? DPC'(1) : '0;
        send(d);
      end
    end
    idle();
    repeat (3) tick();
    check("t6_pulses", rise_q.size() == 2 && vhigh == 2,
          $sformatf("rises=%0d high_cycles=%0d want 2/2", rise_q.size(), vhigh));
    if (rise_q.size() == 2) begin
      check("t6_spacing", rise_q[1] - rise_q[0] == 11,
            $sformatf("spacing %0d want 11", rise_q[1] - rise_q[0]));
    end
`ifdef ENC_HV_POPCOUNT_EN
    if (ones_q.size() == 2) begin
      check("t6_ones", ones_q[0] == 5000 && ones_q[1] == 1,
            $sformatf("got %0d,%0d want 5000,1", ones_q[0], ones_q[1]));
    end
`endif
    hv_ready = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
